// File: rtl/seg_scan_driver_if.sv
// Display-side signal bundle of the seven-segment scan driver.
// The slave side is the driver; the master side supplies enable and nibble data
// and receives the anode/cathode drive.
interface seg_scan_driver_if;
  logic       en;
  logic [3:0] store;
  logic [3:0] AN;
  logic [3:0] AN_pin;
  logic       myCLK;
  logic [7:0] DISPLAY;

  modport master (
    output en, store,
    input  AN, AN_pin, myCLK, DISPLAY
  );

  modport slave (
    input  en, store,
    output AN, AN_pin, myCLK, DISPLAY
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan driver.
// Each digit owns a slot of DIV cycles. The first BLANK cycles of a slot keep
// the anodes dark so the previous digit's cathodes cannot ghost; the cathode
// pattern for the slot is latched on the last blank cycle and held to slot end.
//
// state | meaning
// DIG0  | AN = 1110, digit 0 selected
// DIG1  | AN = 1101, digit 1 selected
// DIG2  | AN = 1011, digit 2 selected
// DIG3  | AN = 0111, digit 3 selected
module seg_scan_driver #(
  parameter int DIV   = 100000,
  parameter int BLANK = 4
) (
  input logic               CLK,
  input logic               Reset,
  seg_scan_driver_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK - 1);

  // State encoding equals the anode code, so AN comes straight off the register.
  typedef enum logic [3:0] {
    DIG0 = 4'b1110,
    DIG1 = 4'b1101,
    DIG2 = 4'b1011,
    DIG3 = 4'b0111
  } dig_e;

  dig_e            dig_q, dig_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      an_pin_q, an_pin_d;
  logic            myclk_q, myclk_d;
  logic [7:0]      disp_q, disp_d;
  logic            wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // State and output registers; reset abandons any slot in progress.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      dig_q    <= DIG0;
      cnt_q    <= '0;
      an_pin_q <= 4'b1111;
      myclk_q  <= 1'b1;
      disp_q   <= 8'hFF;
    end else begin
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      an_pin_q <= an_pin_d;
      myclk_q  <= myclk_d;
      disp_q   <= disp_d;
    end
  end

  // Next state. Registered outputs are computed from the next count so they
  // line up with the count they describe; disabling blanks the display and
  // suppresses any load or wrap that would have happened on that edge.
  always_comb begin
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    an_pin_d = 4'b1111;
    myclk_d  = myclk_q;
    disp_d   = disp_q;
    wrap     = 1'b0;
    if (bus.en) begin
      wrap  = (cnt_q == CNT_LAST);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        case (dig_q)
          DIG0:    dig_d = DIG1;
          DIG1:    dig_d = DIG2;
          DIG2:    dig_d = DIG3;
          default: dig_d = DIG0;
        endcase
      end
      myclk_d  = (cnt_d < CNT_HALF);
      an_pin_d = (cnt_d < CNT_BLNK) ? 4'b1111 : dig_d;
      if (cnt_q == CNT_LOAD) begin
        disp_d = {1'b1, seg_decode(bus.store)};
      end
    end else begin
      disp_d = 8'hFF;
    end
  end

  assign bus.AN      = dig_q;
  assign bus.AN_pin  = an_pin_q;
  assign bus.myCLK   = myclk_q;
  assign bus.DISPLAY = disp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic, checked
// by a scoreboard fed from a slot-arithmetic reference model.
module tb_seg_scan_driver;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] an_pin;
    logic       myclk;
    logic [7:0] disp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: total enabled edges since reset, latched cathodes, blank flag.
  int         m_t;
  logic [7:0] m_disp;
  logic       m_blank;

  function automatic int m_cnt();
    return m_t % DIV;
  endfunction

  function automatic int m_dig();
    return (m_t / DIV) % 4;
  endfunction

  function automatic exp_t m_out();
    exp_t       e;
    logic [3:0] one;
    one      = 4'b0001;
    e.an     = ~(one << m_dig());
    e.myclk  = (m_cnt() < DIV / 2);
    e.an_pin = (m_blank || m_cnt() < BLANK) ? 4'hF : e.an;
    e.disp   = m_disp;
    return e;
  endfunction

  task automatic m_reset();
    m_t     = 0;
    m_disp  = 8'hFF;
    m_blank = 1'b1;
  endtask

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Let the next posedge update the DUT, then sample away from the edge.
  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // One clock of stimulus; pushes the expected post-edge outputs.
  task automatic step(input logic rst_v, input logic en_v, input logic [3:0] st_v);
    @(negedge CLK);
    if (!rst_v && Reset) begin
      #2 Reset = 1'b0;
      #1;
      check_lit("async_rst_AN",      {4'h0, bus.AN},     8'h0E);
      check_lit("async_rst_AN_pin",  {4'h0, bus.AN_pin}, 8'h0F);
      check_lit("async_rst_DISPLAY", bus.DISPLAY,        8'hFF);
      check_lit("async_rst_myCLK",   {7'h0, bus.myCLK},  8'h01);
    end else if (rst_v) begin
      Reset = 1'b1;
    end
    bus.en    = en_v;
    bus.store = st_v;
    if (!Reset) begin
      m_reset();
    end else if (en_v) begin
      if (m_cnt() == BLANK - 1) m_disp = {1'b1, seg_tab[st_v]};
      m_t++;
      m_blank = 1'b0;
    end else begin
      m_disp  = 8'hFF;
      m_blank = 1'b1;
    end
    sb.push_back(m_out());
  endtask

  // Monitor: every cycle is an output beat; compare against the queued expectation.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.AN, bus.AN_pin, bus.myCLK, bus.DISPLAY};
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL scoreboard at %0t: got AN=%b AN_pin=%b myCLK=%b DISPLAY=%h expected AN=%b AN_pin=%b myCLK=%b DISPLAY=%h",
                      $time, got.an, got.an_pin, got.myclk, got.disp, e.an, e.an_pin, e.myclk, e.disp);
      end
    end
  end

  initial begin
    int guard;
    m_reset();
    bus.en    = 1'b0;
    bus.store = 4'h0;
    #1 Reset = 1'b0;
    #2;
    check_lit("reset_AN",      {4'h0, bus.AN},     8'h0E);
    check_lit("reset_AN_pin",  {4'h0, bus.AN_pin}, 8'h0F);
    check_lit("reset_DISPLAY", bus.DISPLAY,        8'hFF);
    check_lit("reset_myCLK",   {7'h0, bus.myCLK},  8'h01);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h5);

    // First slot after release, then four full slots of rotation.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 4'h5);
      if (i == 0) begin
        settle();
        check_lit("blank_AN_pin", {4'h0, bus.AN_pin}, 8'h0F);
      end
      if (i == 1) begin
        settle();
        check_lit("first_load_DISPLAY", bus.DISPLAY,        8'h92);
        check_lit("first_load_AN_pin",  {4'h0, bus.AN_pin}, 8'h0E);
      end
    end
    settle();
    check_lit("rotation_wrap_AN", {4'h0, bus.AN}, 8'h0E);

    // Late store changes are ignored until the next load point.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, (i < 4) ? 4'hA : 4'h3);
      if (i == 6) begin
        settle();
        check_lit("hold_after_load", bus.DISPLAY, 8'h88);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 4'h3);
      if (i == 1) begin
        settle();
        check_lit("next_load", bus.DISPLAY, 8'hB0);
      end
    end

    // Pause at cnt=5 for 10 cycles, then finish the slot.
    guard = 0;
    while (m_cnt() != 5 && guard < 16) begin
      step(1'b1, 1'b1, 4'h7);
      guard++;
    end
    if (guard >= 16) bound_fail("reach_cnt5");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 4'h7);
      if (i == 0) begin
        settle();
        check_lit("pause_AN_pin",  {4'h0, bus.AN_pin}, 8'h0F);
        check_lit("pause_DISPLAY", bus.DISPLAY,        8'hFF);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h7);
    settle();
    check_lit("resume_wrap_myCLK", {7'h0, bus.myCLK}, 8'h01);

    // Asynchronous reset at cnt=1 of digit 2.
    guard = 0;
    while (!(m_dig() == 2 && m_cnt() == 1) && guard < 40) begin
      step(1'b1, 1'b1, 4'($urandom_range(0, 15)));
      guard++;
    end
    if (guard >= 40) bound_fail("reach_dig2");
    settle();
    check_lit("pre_reset_AN", {4'h0, bus.AN}, 8'h0B);
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 4'h0);

    // Every nibble through the decoder, one slot each.
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 1'b1, 4'(s));
        if (c == 1) begin
          settle();
          check_lit("decode_dp", {7'h0, bus.DISPLAY[7]}, 8'h01);
        end
      end
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)));
    end
    step(1'b1, 1'b0, 4'h0);
    settle();
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 100000: digit slot length in CLK cycles; legal range DIV >= 4.
REQ-002 SHALL have parameter BLANK, default 4: anode-off cycles at the start of each slot; legal range 1 <= BLANK <= DIV/2.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  scan enable; synchronous.
REQ-006 SHALL have port store  input  4  hex nibble for the currently selected digit, supplied by the display-select stage.
REQ-007 SHALL have port AN  output  4  selected-digit code sent to the display-select stage, active-low one-hot, never blanked.
REQ-008 SHALL have port AN_pin  output  4  anode drive to the board, active-low, blanked during the guard interval.
REQ-009 SHALL have port myCLK  output  1  scan clock sent to the display-select stage.
REQ-010 SHALL have port DISPLAY  output  8  cathode drive, active-low; bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.

Function
REQ-011 SHALL keep slot counter cnt, range 0..DIV-1; increments each cycle while en=1 and wraps DIV-1 -> 0.
REQ-012 SHALL rotate AN on the cnt DIV-1 -> 0 edge: 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap).
REQ-013 SHALL keep AN one-hot-low at all times; AN never takes any other value.
REQ-014 SHALL drive all outputs from registers, with no combinational path from store or en to any output.
REQ-015 SHALL make myCLK = 1 in every cycle where cnt < DIV/2 and 0 otherwise; its rising edge coincides with the cycle in which AN first shows the new digit.
REQ-016 SHALL make AN_pin = 1111 in cycles where cnt < BLANK, and AN_pin = AN in cycles where cnt >= BLANK.
REQ-017 SHALL, on the edge ending the cycle where cnt = BLANK-1, load DISPLAY[6:0] with decode(store); the value is visible from cnt = BLANK.
REQ-018 SHALL hold DISPLAY unchanged until the next load; store changes after the load edge have no effect within the slot.
REQ-019 SHALL use this decode table (hex -> DISPLAY[6:0]): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-020 SHALL hold DISPLAY[7] (dp) at 1 (off) at all times.
REQ-021 SHALL, while en=0: freeze cnt and AN, drive AN_pin = 1111 and DISPLAY = FF, and freeze myCLK.
REQ-022 SHALL, when en returns to 1, resume counting from the frozen cnt; DISPLAY stays FF until the next load point (cnt = BLANK-1 edge).
REQ-023 SHALL, if en falls in the same cycle as a load point or a slot wrap, suppress that load or wrap.

Reset
REQ-024 SHALL, while Reset=0, asynchronously force: cnt=0, AN=1110, AN_pin=1111, DISPLAY=FF, myCLK=1.
REQ-025 SHALL, after Reset deasserts, begin counting on the first CLK edge with en=1; the first slot is digit AN0 (1110), including the blank interval.
REQ-026 SHALL, on reset asserted mid-slot or mid-blank, abandon the slot with no partial load or rotation.

Verification (DIV=8, BLANK=2)
REQ-027 SHALL cover: reset release, en=1, store=5 -> AN=1110; AN_pin=1111 for cycles 0-1; AN_pin=1110 and DISPLAY=8'h92 from cycle 2 to 7.
REQ-028 SHALL cover: 32 cycles with en=1 -> AN sequence 1110,1101,1011,0111,1110; myCLK high 4 cycles / low 4 cycles per slot.
REQ-029 SHALL cover: store=A at the load point, then store=3 at cnt=4 -> DISPLAY stays 8'h88 for the rest of the slot; 8'hB0 only after a later load point.
REQ-030 SHALL cover: en=0 at cnt=5 for 10 cycles -> AN_pin=1111, DISPLAY=FF, cnt and AN frozen; after re-enable, the slot ends 3 cycles later.
REQ-031 SHALL cover: Reset pulsed low at cnt=1 of digit AN2 -> AN=1110 immediately, AN_pin=1111, DISPLAY=FF; no clock edge required.
REQ-032 SHALL cover: all 16 store values over successive slots -> DISPLAY matches the REQ-019 table with bit 7 = 1 in every case.
